// File: rtl/store_pkg.sv
// Shared types for the store read-modify-write sequencer.
package store_pkg;

  // Width of the memory-latency wait counter.
  localparam int LAT_W = 3;

  // Store size as encoded on funct3; 4..7 have no name and are rejected.
  typedef enum logic [2:0] {SB, SH, SW, SD} store_size_t;

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE, ERR} state_t;

endpackage

// File: rtl/store_merge.sv
// Merge datapath: low lanes of rs2 overwrite the low lanes of the read doubleword.
module store_merge
  import store_pkg::*;
(
  input  logic [63:0]  rdata,
  input  logic [63:0]  rs2,
  input  store_size_t  size,
  output logic [63:0]  wdata
);

  // Select how many low bytes come from rs2; a full doubleword ignores rdata.
  always_comb begin
    wdata = rs2;
    case (size)
      SB:      wdata = {rdata[63:8],  rs2[7:0]};
      SH:      wdata = {rdata[63:16], rs2[15:0]};
      SW:      wdata = {rdata[63:32], rs2[31:0]};
      default: wdata = rs2;
    endcase
  end

endmodule

// File: rtl/store_rmw_ctrl.sv
// Store sequencer: read-modify-write for sb/sh/sw, direct write for sd.
// Owns the data-memory port from request acceptance until done/err.
//
//   state | meaning
//   IDLE  | port released, waiting for start
//   READ  | one-cycle read strobe, wait counter loaded
//   WAIT  | counting memory latency, rdata captured on the last cycle
//   WRITE | one-cycle write strobe with merged data
//   DONE  | one-cycle completion pulse
//   ERR   | one-cycle reject pulse for an illegal funct3
module store_rmw_ctrl
  import store_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [63:0] addr,
  input  logic [63:0] rs2,
  input  logic [63:0] mem_rdata,
  output logic [63:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [63:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  state_t            state_q, state_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [63:0]       addr_q, addr_d;
  logic [63:0]       rs2_q, rs2_d;
  logic [63:0]       rdata_q, rdata_d;
  logic [LAT_W-1:0]  cnt_q, cnt_d;
  logic [63:0]       merged;

  store_merge u_merge (
    .rdata (rdata_q),
    .rs2   (rs2_q),
    .size  (store_size_t'(funct3_q)),
    .wdata (merged)
  );

  // Next-state logic and op-register capture.
  always_comb begin
    state_d  = state_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    rs2_d    = rs2_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          funct3_d = funct3;
          addr_d   = addr;
          rs2_d    = rs2;
          if (funct3 <= 3'd2)      state_d = READ;
          else if (funct3 == 3'd3) state_d = WRITE;
          else                     state_d = ERR;
        end
      end
      READ: begin
        cnt_d   = LAT_W'(MEM_LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rdata_d = mem_rdata;
          state_d = WRITE;
        end else begin
          cnt_d = cnt_q - LAT_W'(1);
        end
      end
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from registered state only; no input-to-output paths.
  always_comb begin
    busy      = (state_q != IDLE);
    mem_addr  = busy ? addr_q : 64'd0;
    mem_rd    = (state_q == READ);
    mem_wr    = (state_q == WRITE);
    mem_wdata = (state_q == WRITE) ? merged : 64'd0;
    done      = (state_q == DONE);
    err       = (state_q == ERR);
  end

  // State and op registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      funct3_q <= '0;
      addr_q   <= '0;
      rs2_q    <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      rs2_q    <= rs2_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_store_rmw_ctrl.sv
// Directed bench for store_rmw_ctrl with one-cycle and four-cycle memories.
module tb_store_rmw_ctrl;

  localparam logic [63:0] WORD = 64'h1122_3344_5566_7788;
  localparam logic [63:0] GARB = 64'hBADB_ADBA_DBAD_BAD0;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        sel;
  logic [2:0]  funct3;
  logic [63:0] addr, rs2;

  logic        start1, start4;
  logic [63:0] mem_rdata1, mem_rdata4;
  logic [63:0] mem_addr1, mem_addr4, mem_wdata1, mem_wdata4;
  logic        mem_rd1, mem_rd4, mem_wr1, mem_wr4;
  logic        busy1, busy4, done1, done4, err1, err4;
  logic [3:0]  rd_pipe4 = 4'd0;

  logic [63:0] addr_s, wdata_s;
  logic        rd_s, wr_s, busy_s, done_s, err_s;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  assign start1 = start & ~sel;
  assign start4 = start & sel;

  assign addr_s  = sel ? mem_addr4  : mem_addr1;
  assign wdata_s = sel ? mem_wdata4 : mem_wdata1;
  assign rd_s    = sel ? mem_rd4    : mem_rd1;
  assign wr_s    = sel ? mem_wr4    : mem_wr1;
  assign busy_s  = sel ? busy4      : busy1;
  assign done_s  = sel ? done4      : done1;
  assign err_s   = sel ? err4       : err1;

  // One-cycle memory: data valid the cycle after mem_rd, garbage otherwise.
  always @(posedge clk) mem_rdata1 <= mem_rd1 ? WORD : GARB;

  // Four-cycle memory: data valid only exactly four cycles after mem_rd.
  always @(posedge clk) rd_pipe4 <= {rd_pipe4[2:0], mem_rd4};
  assign mem_rdata4 = rd_pipe4[3] ? WORD : GARB;

  store_rmw_ctrl #(.MEM_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .funct3(funct3), .addr(addr),
    .rs2(rs2), .mem_rdata(mem_rdata1), .mem_addr(mem_addr1), .mem_rd(mem_rd1),
    .mem_wr(mem_wr1), .mem_wdata(mem_wdata1), .busy(busy1), .done(done1),
    .err(err1)
  );

  store_rmw_ctrl #(.MEM_LAT(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .funct3(funct3), .addr(addr),
    .rs2(rs2), .mem_rdata(mem_rdata4), .mem_addr(mem_addr4), .mem_rd(mem_rd4),
    .mem_wr(mem_wr4), .mem_wdata(mem_wdata4), .busy(busy4), .done(done4),
    .err(err4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one store on the selected DUT and check it cycle by cycle up to DONE.
  task automatic run_store(input int lat, input logic [2:0] f3, input logic [63:0] a,
                           input logic [63:0] d, input logic [63:0] exp_w,
                           input bit from_done, input string tag);
    start = 1'b1; funct3 = f3; addr = a; rs2 = d;
    if (from_done) begin
      step();
      chk({tag, "_idle_gap_busy"}, busy_s, 1'b0);
    end
    step();
    start = 1'b0; funct3 = 3'd7; addr = '1; rs2 = '1;
    if (f3 == 3'd3) begin
      chk({tag, "_wr"},    wr_s,    1'b1);
      chk({tag, "_rd"},    rd_s,    1'b0);
      chk({tag, "_wdata"}, wdata_s, exp_w);
      chk({tag, "_addr"},  addr_s,  a);
      step();
      chk({tag, "_done"},  done_s,  1'b1);
      chk({tag, "_wr_off"}, wr_s,   1'b0);
    end else begin
      chk({tag, "_rd"},   rd_s,   1'b1);
      chk({tag, "_wr"},   wr_s,   1'b0);
      chk({tag, "_busy"}, busy_s, 1'b1);
      chk({tag, "_addr"}, addr_s, a);
      for (int i = 0; i < lat; i++) begin
        step();
        chk({tag, "_wait_rd"}, rd_s, 1'b0);
        chk({tag, "_wait_wr"}, wr_s, 1'b0);
      end
      step();
      chk({tag, "_wr_strobe"}, wr_s,    1'b1);
      chk({tag, "_wr_rd"},     rd_s,    1'b0);
      chk({tag, "_wdata"},     wdata_s, exp_w);
      chk({tag, "_wr_addr"},   addr_s,  a);
      step();
      chk({tag, "_done"},   done_s, 1'b1);
      chk({tag, "_wr_off"}, wr_s,   1'b0);
      chk({tag, "_busy_d"}, busy_s, 1'b1);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; sel = 1'b0;
    funct3 = 3'd0; addr = '0; rs2 = '0;
    #3;
    chk("rst_addr",  mem_addr1,  64'd0);
    chk("rst_rd",    mem_rd1,    1'b0);
    chk("rst_wr",    mem_wr1,    1'b0);
    chk("rst_wdata", mem_wdata1, 64'd0);
    chk("rst_busy",  busy1,      1'b0);
    chk("rst_done",  done1,      1'b0);
    chk("rst_err",   err1,       1'b0);
    chk("rst_busy4", busy4,      1'b0);
    step();
    step();
    reset = 1'b1;

    // sb, then sh and sw back to back, all with MEM_LAT=1
    run_store(1, 3'd0, 64'h0000_0000_0000_1000, 64'h0000_0000_0000_00AB,
              64'h1122_3344_5566_77AB, 1'b0, "sb");
    step();
    chk("sb_idle_busy", busy_s, 1'b0);
    chk("sb_idle_done", done_s, 1'b0);
    chk("sb_idle_addr", addr_s, 64'd0);
    run_store(1, 3'd1, 64'h0000_0000_0000_2002, 64'hDEAD_BEEF_CAFE_F00D,
              64'h1122_3344_5566_F00D, 1'b0, "sh");
    run_store(1, 3'd2, 64'h0000_0000_0000_3004, 64'hDEAD_BEEF_CAFE_F00D,
              64'h1122_3344_CAFE_F00D, 1'b1, "sw");
    step();
    chk("sw_idle_busy", busy_s, 1'b0);

    // sd skips the read
    run_store(1, 3'd3, 64'h0000_0000_0000_4008, 64'hFFFF_0000_FFFF_0000,
              64'hFFFF_0000_FFFF_0000, 1'b0, "sd");
    step();
    chk("sd_idle_busy", busy_s, 1'b0);

    // illegal funct3
    start = 1'b1; funct3 = 3'd5; addr = 64'h50; rs2 = 64'h1;
    step();
    start = 1'b0;
    chk("err_pulse", err_s,  1'b1);
    chk("err_rd",    rd_s,   1'b0);
    chk("err_wr",    wr_s,   1'b0);
    chk("err_busy",  busy_s, 1'b1);
    step();
    chk("err_off",   err_s,  1'b0);
    chk("err_idle",  busy_s, 1'b0);
    chk("err_wr2",   wr_s,   1'b0);

    // MEM_LAT=4 sw; garbage on mem_rdata except in the last WAIT cycle
    sel = 1'b1;
    run_store(4, 3'd2, 64'h0000_0000_0000_6010, 64'hDEAD_BEEF_CAFE_F00D,
              64'h1122_3344_CAFE_F00D, 1'b0, "lat4_sw");
    step();
    chk("lat4_idle_busy", busy_s, 1'b0);

    // reset mid-WAIT with start held high throughout
    start = 1'b1; funct3 = 3'd2; addr = 64'h7000; rs2 = 64'h5;
    step();
    start = 1'b0;
    chk("rstw_rd", rd_s, 1'b1);
    step();
    step();
    reset = 1'b0;
    start = 1'b1; funct3 = 3'd0; addr = 64'h0000_0000_0000_8001;
    rs2 = 64'h0000_0000_0000_00AB;
    #1;
    chk("rstw_busy",  busy_s,  1'b0);
    chk("rstw_addr",  addr_s,  64'd0);
    chk("rstw_rd0",   rd_s,    1'b0);
    chk("rstw_wr",    wr_s,    1'b0);
    chk("rstw_wdata", wdata_s, 64'd0);
    chk("rstw_done",  done_s,  1'b0);
    chk("rstw_err",   err_s,   1'b0);
    step();
    chk("rstw_hold1", busy_s, 1'b0);
    step();
    chk("rstw_hold2", busy_s, 1'b0);
    reset = 1'b1;
    run_store(4, 3'd0, 64'h0000_0000_0000_8001, 64'h0000_0000_0000_00AB,
              64'h1122_3344_5566_77AB, 1'b0, "post_rst_sb");
    step();
    chk("final_idle", busy_s, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
